// File: rtl/serial_to_parallel_framer.sv
// Serial-to-parallel framer: assembles WIDTH-bit words from a qualified bit stream into a handshaked holding register.
// Optional even-parity trailer bit per frame when S2P_PARITY_CHECK_EN is defined.
module serial_to_parallel_framer #(
    parameter int WIDTH     = 7,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             sof,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overflow,
    output logic             parity_err
);

`ifdef S2P_PARITY_CHECK_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = $clog2(FRAME + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] asm_q, asm_nxt;
    logic [WIDTH-1:0] base, shifted, word;
    logic             word_perr;
    logic             frame_done;

    always_comb begin
        base = sof ? '0 : asm_q;
        if (MSB_FIRST) begin
            shifted = {base[WIDTH-2:0], din};
        end else begin
            shifted = {din, base[WIDTH-1:1]};
        end
        frame_done = din_valid && !sof && (cnt == CW'(FRAME - 1));
        asm_nxt    = asm_q;
        word       = shifted;
        word_perr  = 1'b0;
`ifdef S2P_PARITY_CHECK_EN
        // The closing bit is the parity trailer; it is checked but never shifted into the word.
        word      = asm_q;
        word_perr = (^asm_q) ^ din;
        if (din_valid && !frame_done) begin
            asm_nxt = shifted;
        end
`else
        if (din_valid) begin
            asm_nxt = shifted;
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (din_valid) begin
            if (sof) begin
                state_nxt = SHIFT;
                cnt_nxt   = CW'(1);
            end else if (frame_done) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else begin
                state_nxt = SHIFT;
                cnt_nxt   = cnt + 1'b1;
            end
        end else if (sof) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            asm_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            asm_q <= asm_nxt;
        end
    end

    logic perr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            perr_q     <= 1'b0;
        end else if (frame_done) begin
            // A completed word may only replace the held one if that one is leaving on this edge.
            if (!dout_valid || dout_ready) begin
                dout       <= word;
                perr_q     <= word_perr;
                dout_valid <= 1'b1;
            end else begin
                overflow <= 1'b1;
            end
        end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

    assign busy = (state == SHIFT);

`ifdef S2P_PARITY_CHECK_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_to_parallel_framer.sv
// Randomised scoreboard bench for serial_to_parallel_framer (MSB-first and LSB-first instances share stimulus).
// Honours S2P_PARITY_CHECK_EN to switch the reference model to WIDTH+1-bit frames.
module tb_serial_to_parallel_framer;

    localparam int WIDTH = 7;
`ifdef S2P_PARITY_CHECK_EN
    localparam int FRAME = WIDTH + 1;
    localparam bit PAR   = 1'b1;
`else
    localparam int FRAME = WIDTH;
    localparam bit PAR   = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, din, din_valid, sof, dout_ready;
    logic [WIDTH-1:0] dout_m, dout_l;
    logic             dval_m, dval_l, busy_m, busy_l, ovf_m, ovf_l, perr_m, perr_l;

    serial_to_parallel_framer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sof(sof),
        .dout(dout_m), .dout_valid(dval_m), .dout_ready(dout_ready),
        .busy(busy_m), .overflow(ovf_m), .parity_err(perr_m)
    );

    serial_to_parallel_framer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sof(sof),
        .dout(dout_l), .dout_valid(dval_l), .dout_ready(dout_ready),
        .busy(busy_l), .overflow(ovf_l), .parity_err(perr_l)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] msb;
        logic [WIDTH-1:0] lsb;
        logic             perr;
    } exp_t;

    exp_t exp_q[$];
    bit   bits_q[$];
    bit   m_full, m_ovf;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a frame is simply the list of accepted bits since the last boundary.
    task automatic model(input bit v, input bit d, input bit s, input bit r, input bit rs);
        bit   complete;
        exp_t e;
        int   ones;
        if (rs) begin
            bits_q.delete();
            exp_q.delete();
            m_full = 0;
            m_ovf  = 0;
            return;
        end
        complete = 0;
        if (s) bits_q.delete();
        if (v) begin
            bits_q.push_back(d);
            if (bits_q.size() == FRAME) begin
                complete = 1;
                ones     = 0;
                e.msb    = '0;
                e.lsb    = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    e.msb[WIDTH-1-i] = bits_q[i];
                    e.lsb[i]         = bits_q[i];
                    ones += int'(bits_q[i]);
                end
                if (PAR) ones += int'(bits_q[WIDTH]);
                e.perr = PAR && (ones % 2 == 1);
                bits_q.delete();
            end
        end
        if (complete) begin
            if (!m_full || r) begin
                exp_q.push_back(e);
                m_full = 1;
            end else begin
                m_ovf = 1;
            end
        end else if (m_full && r) begin
            m_full = 0;
        end
    endtask

    task automatic step(input bit v, input bit d, input bit s, input bit r, input bit rs);
        din_valid = v; din = d; sof = s; dout_ready = r; rst = rs;
        model(v, d, s, r, rs);
        @(posedge clk);
        #2;
        check("busy_m", 32'(busy_m), 32'(bits_q.size() != 0));
        check("busy_l", 32'(busy_l), 32'(bits_q.size() != 0));
        check("dout_valid", 32'(dval_m), 32'(m_full));
        check("dout_valid_l", 32'(dval_l), 32'(m_full));
        check("overflow", 32'(ovf_m), 32'(m_ovf));
        check("overflow_l", 32'(ovf_l), 32'(m_ovf));
    endtask

    task automatic send_bits(input logic [31:0] pat, input int n, input bit r);
        for (int i = n - 1; i >= 0; i--) step(1, pat[i], 0, r, 0);
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input bit r);
        send_bits(32'(w), WIDTH, r);
        if (PAR) step(1, ^w, 0, r, 0);
    endtask

    // Consumer side: a word is consumed whenever valid and ready are both seen between edges.
    always @(negedge clk) begin
        if (rst === 1'b0 && dval_m === 1'b1 && dout_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got word %0h expected none at %0t", dout_m, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_dout_msb", 32'(dout_m), 32'(e.msb));
                check("sb_dout_lsb", 32'(dout_l), 32'(e.lsb));
                check("sb_parity_err", 32'(perr_m), 32'(e.perr));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        din = 0; din_valid = 0; sof = 0; dout_ready = 0; rst = 1;
        @(posedge clk);
        #2;
        step(0, 0, 0, 0, 1);
        check("rst_dout", 32'(dout_m), 32'd0);
        check("rst_perr", 32'(perr_m), 32'd0);

        send_word(7'b1011001, 1);
        check("msb_first_word", 32'(dout_m), 32'(7'b1011001));
        check("lsb_first_word", 32'(dout_l), 32'(7'b1001101));
        check("busy_after_last", 32'(busy_m), 32'd0);
        step(0, 0, 0, 1, 0);

        send_word(7'b1011001, 0);
        send_word(7'b0110110, 0);
        check("ovf_held_word", 32'(dout_m), 32'(7'b1011001));
        check("ovf_sticky", 32'(ovf_m), 32'd1);
        step(0, 0, 0, 0, 1);
        check("ovf_cleared", 32'(ovf_m), 32'd0);

        send_bits(32'b111, 3, 1);
        step(1, 1, 1, 1, 0);
        send_bits(32'b000001, 6, 1);
        if (PAR) step(1, 0, 0, 1, 0);
        check("sof_realign", 32'(dout_m), 32'(7'b1000001));
        step(0, 0, 0, 1, 0);

        send_bits(32'b1111, 4, 1);
        step(0, 0, 0, 1, 1);
        send_word(7'b0101010, 1);
        check("post_rst_word", 32'(dout_m), 32'(7'b0101010));
        check("post_rst_ovf", 32'(ovf_m), 32'd0);
        step(0, 0, 0, 1, 0);

`ifdef S2P_PARITY_CHECK_EN
        send_bits(32'b1011001, 7, 1);
        step(1, 1, 0, 1, 0);
        check("parity_bad", 32'(perr_m), 32'd1);
        send_bits(32'b1011001, 7, 1);
        step(1, 0, 0, 1, 0);
        check("parity_good", 32'(perr_m), 32'd0);
        step(0, 0, 0, 1, 0);
`endif

        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 99) == 0);
        end
        for (int n = 0; n < 600; n++) begin
            step(1, 1'($urandom), 0, 1, 0);
        end
        for (int n = 0; n < FRAME + 2; n++) step(0, 0, 0, 1, 0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_to_parallel_framer.md
SERIAL_TO_PARALLEL_FRAMER -- requirements
Module: serial_to_parallel_framer

Interface
REQ-001 Parameter: WIDTH, default 7, bits per deserialised word; legal range 2..32.
REQ-002 Parameter: MSB_FIRST, default 1; 1 = first received bit lands in dout[WIDTH-1], 0 = first bit lands in dout[0].
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: din  input  1  serial data bit.
REQ-006 Port: din_valid  input  1  din is sampled only when high.
REQ-007 Port: sof  input  1  start-of-frame realignment strobe.
REQ-008 Port: dout  output  WIDTH  completed parallel word, registered.
REQ-009 Port: dout_valid  output  1  dout holds an unconsumed word.
REQ-010 Port: dout_ready  input  1  consumer accepts dout when dout_valid and dout_ready are both high.
REQ-011 Port: busy  output  1  high while a partial word is being collected (bit counter nonzero).
REQ-012 Port: overflow  output  1  sticky flag: a completed word was dropped.
REQ-013 Port: parity_err  output  1  parity error qualifier for dout (see Configuration).

Function
REQ-014 Two-state FSM: IDLE (bit count 0) and SHIFT (1..FRAME-1 bits held); FRAME = WIDTH, or WIDTH+1 with parity enabled.
REQ-015 IDLE->SHIFT on an accepted bit (din_valid=1) that does not complete a frame; SHIFT->IDLE on the accepted bit that completes a frame, on sof, or on rst.
REQ-016 Each accepted bit shifts into the assembly register per MSB_FIRST; cycles with din_valid=0 hold all state.
REQ-017 On the edge sampling the last bit of a frame, the word is written to the dout holding register and dout_valid is set; dout is visible one cycle after the last bit is presented; the bit counter returns to 0.
REQ-018 dout and dout_valid stay stable while dout_valid=1 and dout_ready=0.
REQ-019 Handshake: dout_valid clears on the edge where dout_valid=1 and dout_ready=1, unless a new word completes on that same edge.
REQ-020 A word completing on the same edge as a handshake is loaded; dout_valid stays 1; no overflow.
REQ-021 A word completing while dout_valid=1 and dout_ready=0 is discarded; dout is unchanged; overflow sets and stays 1 until rst.
REQ-022 sof=1 with din_valid=0 discards the partial word and zeroes the counter. sof=1 with din_valid=1 discards the partial word and takes din as bit 0 of a new frame.
REQ-023 sof never affects the dout holding register, dout_valid or overflow.
REQ-024 When WIDTH=2 without parity, each second accepted bit completes a frame; back-to-back frames at full din_valid rate are supported without gaps.

Reset
REQ-025 rst=1 at a clock edge sets dout=0, dout_valid=0, busy=0, overflow=0 and parity_err=0, and clears the counter and assembly register; the FSM enters IDLE.
REQ-026 rst takes priority over sof, din_valid and dout_ready, including mid-frame; a partial frame is lost.

Configuration
REQ-027 Macro S2P_PARITY_CHECK_EN defined: each frame is WIDTH data bits followed by one even-parity bit; the parity bit never appears on dout; parity_err is loaded with dout and is 1 when data^parity is odd.
REQ-028 Macro undefined: FRAME = WIDTH; parity_err is a constant 0; the port list is identical.

Verification
REQ-029 WIDTH=7, MSB_FIRST=1: bits 1,0,1,1,0,0,1 on consecutive cycles with dout_ready=1 -> dout=7'b1011001, dout_valid high one cycle later, busy low after the last bit.
REQ-030 MSB_FIRST=0, same bits -> dout=7'b1001101.
REQ-031 dout_ready=0: two full frames -> first word held on dout, overflow=1 after the 14th bit, and dout still equals the first word.
REQ-032 Three bits, then sof with din_valid=1, then 6 more bits 0,0,0,0,0,1 (MSB first, first bit 1) -> dout=7'b1000001; the partial bits never appear.
REQ-033 rst pulsed after 4 bits, then 7 bits 0101010 -> dout=7'b0101010 and overflow=0.
REQ-034 With S2P_PARITY_CHECK_EN: data 1011001 plus parity bit 1 -> dout=7'b1011001, parity_err=1; with parity bit 0 -> parity_err=0.
